neuron_mac_engine: RTL and testbench
====================================

Name: neuron_mac_engine

Overview:
Parametrised successor to the single neuron datapath on the neuron_control conduit. Fetches packed image and weight words through two independent read-only Avalon-MM masters and computes a signed dot product over kernel_size elements, LANES elements per word. Result is saturated to OUT_W bits and exposed with a start/clear/done handshake for the HPS-side controller.

Parameters:
LANES, 4, signed elements packed per bus word (lane 0 = bits [DATA_W-1:0])
DATA_W, 8, element width, two's complement
ADDR_W, 32, byte address width of both masters
ACC_W, 40, internal accumulator width; must be >= 2*DATA_W + log2(max kernel)
OUT_W, 32, width of out_neuron
KS_W, 16, width of kernel_size

Ports:
clk_clk  in  1  clock
reset_reset  in  1  asynchronous active-high reset
ctl_start  in  1  single-cycle start pulse
ctl_clear  in  1  abort / acknowledge; clears done and result
ctl_kernel_size  in  KS_W  element count, sampled at start
ctl_base_addr_img  in  ADDR_W  image base byte address, sampled at start
ctl_base_addr_wei  in  ADDR_W  weight base byte address, sampled at start
ctl_busy  out  1  high from start accept until done
ctl_done  out  1  result valid, sticky
ctl_out_neuron  out  OUT_W  saturated signed result
ctl_addr_img  out  ADDR_W  current image fetch address
ctl_addr_wei  out  ADDR_W  current weight fetch address
img_read  out  1  Avalon read request, image master
img_address  out  ADDR_W  image word address (byte, word aligned)
img_readdata  in  LANES*DATA_W  image data
img_waitrequest  in  1  image stall
wei_read  out  1  Avalon read request, weight master
wei_address  out  ADDR_W  weight word address
wei_readdata  in  LANES*DATA_W  weight data
wei_waitrequest  in  1  weight stall

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator and counters 0.
- States: IDLE, FETCH, MAC, DONE.
- IDLE: ctl_start=1 -> latch kernel_size and both bases, acc=0, remaining=kernel_size; go FETCH (busy=1 next cycle). If kernel_size==0 -> go directly to DONE with out_neuron=0.
- FETCH: img_read/wei_read asserted for each master whose word is not yet captured; address held stable. A master's readdata is captured in the cycle its read=1 and waitrequest=0; its read drops next cycle. Masters are independent; both captured -> MAC.
- MAC (1 cycle): sum of LANES signed DATA_W x DATA_W products added to acc (sign-extended to ACC_W). Lanes with index >= remaining contribute 0 (partial last word). remaining -= min(remaining, LANES); both addresses += LANES*DATA_W/8. remaining==0 -> DONE, else FETCH.
- Min throughput 2 cycles/word with zero wait states; done rises 1 cycle after final MAC.
- DONE: out_neuron = acc saturated to signed OUT_W range (max 2^(OUT_W-1)-1, min -2^(OUT_W-1)); done=1, busy=0; held until clear or start.
- start in DONE: restarts as from IDLE, done cleared same edge. start in FETCH/MAC ignored.
- clear in IDLE/DONE/MAC: next cycle IDLE, done=0, out_neuron=0, acc=0.
- clear in FETCH with a read outstanding: recorded as pending; reads kept asserted until accepted (Avalon protocol), data discarded, then IDLE. No new reads issued after clear.
- start and clear same cycle: clear wins, start dropped.
- Address wrap at 2^ADDR_W: wraps silently, no error.
- ctl_addr_img/wei mirror internal address registers.

Optional Feature:
Macro NEURON_RELU_EN. Defined: negative saturated result is replaced by 0 at DONE (out_neuron >= 0 always). Undefined: signed saturated result output unchanged.

Test Plan:
- kernel_size=4, img word bytes {1,2,3,4}, wei {1,1,1,1}, no stalls -> out_neuron=10, done 3 cycles after start, exactly one read per master.
- kernel_size=5, img words {1,2,3,4},{5,9,9,9}, wei all 2 -> 30; lanes 1-3 of word 2 ignored, addresses end at base+8.
- img_waitrequest high 3 cycles, wei 0 cycles on each word -> wei_read drops after 1 cycle, img_read held 4 cycles, result unchanged.
- kernel_size=0 -> done next cycle, out_neuron=0, no reads issued.
- Elements all -128 x -128, OUT_W=16, kernel_size=8 -> saturates to 32767; all -128 x 127 -> -32768 (0 with NEURON_RELU_EN).
- clear during stalled FETCH -> read held until waitrequest low, then IDLE, done=0, no further reads; reset_reset mid-MAC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/neuron_mac_engine.sv
// Signed dot-product engine: fetches packed image/weight words over two Avalon-MM
// read masters, accumulates LANES products per word, saturates at DONE. Option: NEURON_RELU_EN.
module neuron_mac_engine #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int KS_W   = 16
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic                      ctl_start,
  input  logic                      ctl_clear,
  input  logic [KS_W-1:0]           ctl_kernel_size,
  input  logic [ADDR_W-1:0]         ctl_base_addr_img,
  input  logic [ADDR_W-1:0]         ctl_base_addr_wei,
  output logic                      ctl_busy,
  output logic                      ctl_done,
  output logic [OUT_W-1:0]          ctl_out_neuron,
  output logic [ADDR_W-1:0]         ctl_addr_img,
  output logic [ADDR_W-1:0]         ctl_addr_wei,
  output logic                      img_read,
  output logic [ADDR_W-1:0]         img_address,
  input  logic [LANES*DATA_W-1:0]   img_readdata,
  input  logic                      img_waitrequest,
  output logic                      wei_read,
  output logic [ADDR_W-1:0]         wei_address,
  input  logic [LANES*DATA_W-1:0]   wei_readdata,
  input  logic                      wei_waitrequest
);

  localparam int WORD_W = LANES * DATA_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LANES * DATA_W / 8);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;

  state_t                    state, state_nx;
  logic [KS_W-1:0]           remaining, rem_nx;
  logic signed [ACC_W-1:0]   acc, acc_nx;
  logic [WORD_W-1:0]         img_word, wei_word;
  logic                      img_got, wei_got, clr_pend;
  logic                      img_hit, wei_hit, img_have, wei_have;
  logic                      start_ok, clear_now, fetch_end, fetch_abort;

  // Sum of LANES signed products; lanes at or beyond the remaining count are masked.
  function automatic logic signed [ACC_W-1:0] mac_sum(input logic [WORD_W-1:0] a_word,
                                                      input logic [WORD_W-1:0] b_word,
                                                      input logic [KS_W-1:0]   rem);
    logic signed [ACC_W-1:0]    s;
    logic signed [DATA_W-1:0]   a, b;
    logic signed [2*DATA_W-1:0] p;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      a = a_word[i*DATA_W +: DATA_W];
      b = b_word[i*DATA_W +: DATA_W];
      p = a * b;
      if (i < int'(rem))
        s = s + $signed({{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p});
    end
    return s;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > OUT_MAX)      r = OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) r = OUT_MIN[OUT_W-1:0];
    else                  r = v[OUT_W-1:0];
`ifdef NEURON_RELU_EN
    if (r < 0) r = '0;
`endif
    return r;
  endfunction

  assign img_read    = (state == FETCH) && !img_got;
  assign wei_read    = (state == FETCH) && !wei_got;
  assign img_address = ctl_addr_img;
  assign wei_address = ctl_addr_wei;
  assign img_hit     = img_read && !img_waitrequest;
  assign wei_hit     = wei_read && !wei_waitrequest;
  assign img_have    = img_got || img_hit;
  assign wei_have    = wei_got || wei_hit;
  assign fetch_end   = (state == FETCH) && img_have && wei_have;
  assign fetch_abort = fetch_end && (clr_pend || ctl_clear);
  assign start_ok    = ctl_start && !ctl_clear && (state == IDLE || state == DONE);
  assign clear_now   = ctl_clear && (state != FETCH);
  assign rem_nx      = (remaining > KS_W'(LANES)) ? remaining - KS_W'(LANES) : '0;
  assign acc_nx      = acc + mac_sum(img_word, wei_word, remaining);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (ctl_clear)      state_nx = IDLE;
        else if (ctl_start) state_nx = (ctl_kernel_size == '0) ? DONE : FETCH;
      end
      FETCH: if (fetch_end) state_nx = (clr_pend || ctl_clear) ? IDLE : MAC;
      MAC: begin
        if (ctl_clear)           state_nx = IDLE;
        else if (rem_nx == '0)   state_nx = DONE;
        else                     state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Fetched words are pure data and need no reset.
  always_ff @(posedge clk_clk) begin
    if (img_hit) img_word <= img_readdata;
    if (wei_hit) wei_word <= wei_readdata;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      remaining      <= '0;
      acc            <= '0;
      img_got        <= 1'b0;
      wei_got        <= 1'b0;
      clr_pend       <= 1'b0;
      ctl_busy       <= 1'b0;
      ctl_done       <= 1'b0;
      ctl_out_neuron <= '0;
      ctl_addr_img   <= '0;
      ctl_addr_wei   <= '0;
    end else if (clear_now || fetch_abort) begin
      remaining      <= '0;
      acc            <= '0;
      img_got        <= 1'b0;
      wei_got        <= 1'b0;
      clr_pend       <= 1'b0;
      ctl_busy       <= 1'b0;
      ctl_done       <= 1'b0;
      ctl_out_neuron <= '0;
    end else if (start_ok) begin
      remaining      <= ctl_kernel_size;
      acc            <= '0;
      img_got        <= 1'b0;
      wei_got        <= 1'b0;
      clr_pend       <= 1'b0;
      ctl_busy       <= 1'b1;
      ctl_done       <= 1'b0;
      ctl_addr_img   <= ctl_base_addr_img;
      ctl_addr_wei   <= ctl_base_addr_wei;
    end else begin
      case (state)
        FETCH: begin
          if (ctl_clear) clr_pend <= 1'b1;
          if (fetch_end) begin
            img_got <= 1'b0;
            wei_got <= 1'b0;
          end else begin
            if (img_hit) img_got <= 1'b1;
            if (wei_hit) wei_got <= 1'b1;
          end
        end
        MAC: begin
          acc          <= acc_nx;
          remaining    <= rem_nx;
          ctl_addr_img <= ctl_addr_img + STEP;
          ctl_addr_wei <= ctl_addr_wei + STEP;
        end
        DONE: begin
          ctl_out_neuron <= sat_out(acc);
          ctl_done       <= 1'b1;
          ctl_busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Scoreboard bench for neuron_mac_engine: directed jobs against small word memories
// with programmable wait states; a monitor checks each result as done rises.
module tb_neuron_mac_engine;
  localparam int LANES = 4, DATA_W = 8, ADDR_W = 32, ACC_W = 40, OUT_W = 16, KS_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, clear = 1'b0;
  logic [KS_W-1:0]   ks = '0;
  logic [ADDR_W-1:0] base_img = '0, base_wei = '0;
  logic              busy, done;
  logic [OUT_W-1:0]  out_neuron;
  logic [ADDR_W-1:0] addr_img, addr_wei, img_address, wei_address;
  logic              img_read, wei_read, img_waitrequest, wei_waitrequest;
  logic [31:0]       img_readdata, wei_readdata;

  logic [31:0] img_mem [256];
  logic [31:0] wei_mem [256];
  int img_stall = 0, wei_stall = 0;
  int img_wcnt = 0, wei_wcnt = 0;
  int img_acc = 0, wei_acc = 0, img_rcyc = 0, wei_rcyc = 0;

  int checks = 0, errors = 0;
  logic signed [OUT_W-1:0] exp_q[$];

  neuron_mac_engine #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W),
                      .OUT_W(OUT_W), .KS_W(KS_W)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .ctl_start(start), .ctl_clear(clear), .ctl_kernel_size(ks),
    .ctl_base_addr_img(base_img), .ctl_base_addr_wei(base_wei),
    .ctl_busy(busy), .ctl_done(done), .ctl_out_neuron(out_neuron),
    .ctl_addr_img(addr_img), .ctl_addr_wei(addr_wei),
    .img_read(img_read), .img_address(img_address), .img_readdata(img_readdata),
    .img_waitrequest(img_waitrequest),
    .wei_read(wei_read), .wei_address(wei_address), .wei_readdata(wei_readdata),
    .wei_waitrequest(wei_waitrequest)
  );

  initial forever #5 clk = ~clk;

  assign img_readdata    = img_mem[img_address[9:2]];
  assign wei_readdata    = wei_mem[wei_address[9:2]];
  assign img_waitrequest = img_read && (img_wcnt < img_stall);
  assign wei_waitrequest = wei_read && (wei_wcnt < wei_stall);

  always @(posedge clk) begin
    if (img_read) begin
      img_rcyc <= img_rcyc + 1;
      if (img_waitrequest) img_wcnt <= img_wcnt + 1;
      else begin img_wcnt <= 0; img_acc <= img_acc + 1; end
    end
    if (wei_read) begin
      wei_rcyc <= wei_rcyc + 1;
      if (wei_waitrequest) wei_wcnt <= wei_wcnt + 1;
      else begin wei_wcnt <= 0; wei_acc <= wei_acc + 1; end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry consumed per rising edge of done.
  initial begin
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else check("out_neuron", longint'($signed(out_neuron)), longint'(exp_q.pop_front()));
        check("busy_at_done", longint'(busy), 0);
      end
      done_q = done;
    end
  end

  task automatic pulse_start(input logic [KS_W-1:0] k, input logic [31:0] bi, input logic [31:0] bw);
    @(negedge clk);
    ks = k; base_img = bi; base_wei = bw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input logic [KS_W-1:0] k, input logic [31:0] bi, input logic [31:0] bw,
                         input logic signed [OUT_W-1:0] exp, output int lat);
    exp_q.push_back(exp);
    pulse_start(k, bi, bw);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", lat, -1);
  endtask

  initial begin
    int lat, ia, wa, ir, wr;
    foreach (img_mem[i]) begin img_mem[i] = '0; wei_mem[i] = '0; end
    img_mem[64] = 32'h04030201; img_mem[65] = 32'h09090905;
    wei_mem[128] = 32'h01010101; wei_mem[129] = 32'h01010101;
    wei_mem[160] = 32'h02020202; wei_mem[161] = 32'h02020202;
    img_mem[80] = 32'h80808080; img_mem[81] = 32'h80808080;
    wei_mem[80] = 32'h80808080; wei_mem[81] = 32'h80808080;
    wei_mem[96] = 32'h7f7f7f7f; wei_mem[97] = 32'h7f7f7f7f;

    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out", out_neuron, 0);
    check("reset_read", {img_read, wei_read}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single word, no stalls
    ia = img_acc; wa = wei_acc; ir = img_rcyc; wr = wei_rcyc;
    run_job(16'd4, 32'h100, 32'h200, 16'sd10, lat);
    check("t1_latency", lat, 3);
    check("t1_img_reads", img_acc - ia, 1);
    check("t1_wei_reads", wei_acc - wa, 1);
    check("t1_img_rcyc", img_rcyc - ir, 1);

    // Partial last word
    run_job(16'd5, 32'h100, 32'h280, 16'sd30, lat);
    check("t2_addr_img", addr_img, 32'h108);
    check("t2_addr_wei", addr_wei, 32'h288);

    // Image stalls 3 cycles per word
    img_stall = 3;
    ia = img_acc; ir = img_rcyc; wr = wei_rcyc;
    run_job(16'd5, 32'h100, 32'h280, 16'sd30, lat);
    check("t3_img_rcyc", img_rcyc - ir, 8);
    check("t3_wei_rcyc", wei_rcyc - wr, 2);
    check("t3_img_reads", img_acc - ia, 2);
    img_stall = 0;

    // Empty kernel
    ia = img_acc; wa = wei_acc;
    run_job(16'd0, 32'h100, 32'h200, 16'sd0, lat);
    check("t4_latency", lat, 1);
    check("t4_reads", (img_acc - ia) + (wei_acc - wa), 0);

    // Saturation both directions
    run_job(16'd8, 32'h140, 32'h140, 16'sd32767, lat);
`ifdef NEURON_RELU_EN
    run_job(16'd8, 32'h140, 32'h180, 16'sd0, lat);
`else
    run_job(16'd8, 32'h140, 32'h180, -16'sd32768, lat);
`endif

    // Clear while the image read is stalled
    img_stall = 5;
    ia = img_acc; wa = wei_acc;
    pulse_start(16'd4, 32'h100, 32'h200);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t6_read_held", img_read, 1);
    lat = 0;
    while (busy && lat < 50) begin @(negedge clk); lat++; end
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_out", out_neuron, 0);
    repeat (5) @(negedge clk);
    check("t6_img_reads", img_acc - ia, 1);
    check("t6_wei_reads", wei_acc - wa, 1);
    check("t6_no_read", {img_read, wei_read}, 0);
    img_stall = 0;

    // Start and clear together: clear wins
    @(negedge clk);
    start = 1'b1; clear = 1'b1; ks = 16'd4;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("t7_busy", busy, 0);

    // Asynchronous reset during MAC
    run_job(16'd4, 32'h100, 32'h200, 16'sd10, lat);
    pulse_start(16'd8, 32'h100, 32'h200);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t8_busy", busy, 0);
    check("t8_done", done, 0);
    check("t8_out", out_neuron, 0);
    check("t8_addr", addr_img | addr_wei, 0);
    check("t8_read", {img_read, wei_read}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t8_idle", {busy, done}, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
